// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and sizing helpers for the seven-segment display arbiter.
// Optional feature macro: SEG_ARB_IDLE_HOLD_EN (hold last value on the display while idle).
package seg_pkg;

    localparam int BCD_W      = 16;
    localparam int SEG_DIGITS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Counter must hold DWELL_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle between the value producers and the arbiter.
interface seg_display_arbiter_if #(
    parameter int NUM_SRC = 4
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]                    req_i;
    logic [NUM_SRC-1:0][seg_pkg::BCD_W-1:0] bcd_i;
    logic [NUM_SRC-1:0]                    gnt_o;
    logic [SRC_W-1:0]                      src_o;
    logic [seg_pkg::BCD_W-1:0]             bcd_o;
    logic                                  busy_o;

    modport master (
        output req_i, bcd_i,
        input  gnt_o, src_o, bcd_o, busy_o
    );

    modport slave (
        input  req_i, bcd_i,
        output gnt_o, src_o, bcd_o, busy_o
    );

endinterface

// File: rtl/seg_display_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
module seg_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        logic found;
        int   p;
        win_o = '0;
        idx_o = '0;
        any_o = |req_i;
        found = 1'b0;
        p     = 0;
        for (int i = 0; i < N; i++) begin
            p = int'(ptr_i) + i;
            if (p >= N) p = p - N;
            if (!found && req_i[p]) begin
                found    = 1'b1;
                idx_o    = IW'(p);
                win_o[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of the 4-digit BCD display with a minimum per-owner dwell.
// Optional feature macro: SEG_ARB_IDLE_HOLD_EN.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_arbiter_if.slave  bus
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = cnt_width(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] gnt_q,   gnt_d;
    logic [SRC_W-1:0]   src_q,   src_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SRC_W-1:0]   ptr_q,   ptr_d;

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [NUM_SRC-1:0] a_win, b_win;
    logic [SRC_W-1:0]   a_idx, b_idx;
    logic               a_any, b_any;
    logic [SRC_W-1:0]   owner_nxt;

    assign owner_nxt = next_idx(src_q);

    // Fresh arbitration from the pointer: used from IDLE and when the owner lets go.
    seg_rr_picker #(.N(NUM_SRC), .IW(SRC_W)) u_pick_ptr (
        .req_i (bus.req_i),
        .ptr_i (ptr_q),
        .win_o (a_win),
        .idx_o (a_idx),
        .any_o (a_any)
    );

    // Challengers only: the owner is masked so b_any means "someone else wants it".
    seg_rr_picker #(.N(NUM_SRC), .IW(SRC_W)) u_pick_sw (
        .req_i (bus.req_i & ~gnt_q),
        .ptr_i (owner_nxt),
        .win_o (b_win),
        .idx_o (b_idx),
        .any_o (b_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        src_d   = src_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (a_any) begin
                    state_d = SHOW;
                    gnt_d   = a_win;
                    src_d   = a_idx;
                    bcd_d   = bus.bcd_i[a_idx];
                    cnt_d   = CNT_LOAD;
                    ptr_d   = next_idx(a_idx);
                end
            end
            SHOW: begin
                if (!bus.req_i[src_q]) begin
                    if (a_any) begin
                        gnt_d = a_win;
                        src_d = a_idx;
                        bcd_d = bus.bcd_i[a_idx];
                        cnt_d = CNT_LOAD;
                        ptr_d = next_idx(a_idx);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
`ifdef SEG_ARB_IDLE_HOLD_EN
                        bcd_d   = bcd_q;
`else
                        bcd_d   = '0;
`endif
                    end
                end else if (cnt_q == '0 && b_any) begin
                    gnt_d = b_win;
                    src_d = b_idx;
                    bcd_d = bus.bcd_i[b_idx];
                    cnt_d = CNT_LOAD;
                    ptr_d = next_idx(b_idx);
                end else begin
                    bcd_d = bus.bcd_i[src_q];
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            src_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            src_q   <= src_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt_o  = gnt_q;
    assign bus.src_o  = src_q;
    assign bus.bcd_o  = bcd_q;
    assign bus.busy_o = (state_q == SHOW);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed scoreboard bench for seg_display_arbiter (NUM_SRC=4, DWELL_CYCLES=8).
module tb_seg_display_arbiter;

    localparam int N = 4;
    localparam int D = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_display_arbiter_if #(.NUM_SRC(N)) bus ();

    seg_display_arbiter #(.NUM_SRC(N), .DWELL_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  src;
        logic [15:0] bcd;
        logic        busy;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic [3:0][15:0] slices = '0;

    exp_t  m_e;
    string m_nm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t ex(input logic [3:0] g, input logic [1:0] s,
                                input logic [15:0] b, input logic bz);
        exp_t e;
        e.gnt = g; e.src = s; e.bcd = b; e.busy = bz;
        return e;
    endfunction

    function automatic logic [15:0] idle_bcd(input logic [15:0] last);
`ifdef SEG_ARB_IDLE_HOLD_EN
        return last;
`else
        return 16'h0000;
`endif
    endfunction

    // Drive one cycle of stimulus and queue what must appear after that edge.
    task automatic step(input logic [3:0] req, input exp_t e, input string nm);
        @(negedge clk);
        bus.req_i = req;
        bus.bcd_i = slices;
        q.push_back(e);
        nq.push_back(nm);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e  = q.pop_front();
            m_nm = nq.pop_front();
            chk({m_nm, ".gnt"},  32'(bus.gnt_o),  32'(m_e.gnt));
            chk({m_nm, ".src"},  32'(bus.src_o),  32'(m_e.src));
            chk({m_nm, ".bcd"},  32'(bus.bcd_o),  32'(m_e.bcd));
            chk({m_nm, ".busy"}, 32'(bus.busy_o), 32'(m_e.busy));
            chk({m_nm, ".onehot"}, 32'($onehot0(bus.gnt_o)), 32'd1);
        end
    end

    initial begin
        bus.req_i = '0;
        bus.bcd_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.gnt",  32'(bus.gnt_o),  0);
        chk("reset.src",  32'(bus.src_o),  0);
        chk("reset.bcd",  32'(bus.bcd_o),  0);
        chk("reset.busy", 32'(bus.busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, ex(4'b0000, 2'd0, 16'h0000, 1'b0), "idle0");
        step(4'b0000, ex(4'b0000, 2'd0, 16'h0000, 1'b0), "idle1");

        slices[0] = 16'h1234;
        step(4'b0001, ex(4'b0001, 2'd0, 16'h1234, 1'b1), "single.grant");
        slices[0] = 16'h5678;
        step(4'b0001, ex(4'b0001, 2'd0, 16'h5678, 1'b1), "single.track");

        // Asynchronous reset between edges while source 0 is showing.
        @(negedge clk);
        bus.req_i = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("areset.gnt",  32'(bus.gnt_o),  0);
        chk("areset.src",  32'(bus.src_o),  0);
        chk("areset.bcd",  32'(bus.bcd_o),  0);
        chk("areset.busy", 32'(bus.busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        slices = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < D; c++) begin
                if (g == 4 && c > 0) break;
                step(4'b1111, ex(4'b0001 << (g % 4), 2'(g % 4), 16'(16'h1111 * (g % 4 + 1)), 1'b1),
                     $sformatf("rr.g%0d.c%0d", g, c));
            end
        end
        step(4'b0000, ex(4'b0000, 2'd0, idle_bcd(16'h1111), 1'b0), "rr.release");

        slices[2] = 16'hABCD;
        step(4'b0100, ex(4'b0100, 2'd2, 16'hABCD, 1'b1), "early.grant");
        step(4'b0100, ex(4'b0100, 2'd2, 16'hABCD, 1'b1), "early.cnt6");
        step(4'b0100, ex(4'b0100, 2'd2, 16'hABCD, 1'b1), "early.cnt5");
        step(4'b0000, ex(4'b0000, 2'd2, idle_bcd(16'hABCD), 1'b0), "early.release");

        slices[0] = 16'h0042;
        slices[3] = 16'h9F00;
        for (int c = 0; c < 20; c++)
            step(4'b0001, ex(4'b0001, 2'd0, 16'h0042, 1'b1), $sformatf("solo.c%0d", c));
        step(4'b1001, ex(4'b1000, 2'd3, 16'h9F00, 1'b1), "late.switch");
        step(4'b0001, ex(4'b0001, 2'd0, 16'h0042, 1'b1), "handoff");
        step(4'b0000, ex(4'b0000, 2'd0, idle_bcd(16'h0042), 1'b0), "final.release");

        repeat (2) @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
